fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 'h0, meaning PC of the first fetch after reset.
REQ-002 The block SHALL expose parameter BUF_DEPTH, default 2, meaning instruction buffer entries (power of two, 2..8).
REQ-003 The block SHALL provide clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL provide reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL provide ImemReqValid_F  output  1  fetch request valid.
REQ-006 The block SHALL provide ImemReqReady_F  input  1  memory accepts request this cycle.
REQ-007 The block SHALL provide ImemReqAdr_F  output  `XLEN  fetch address, word aligned.
REQ-008 The block SHALL provide ImemRespValid_F  input  1  response beat valid; in order, no backpressure.
REQ-009 The block SHALL provide ImemRespData_F  input  `WORD_SIZE  fetched instruction.
REQ-010 The block SHALL provide Redirect_F  input  1  PC redirect (branch/jump resolved downstream).
REQ-011 The block SHALL provide RedirectPC_F  input  `XLEN  redirect target; bits [1:0] ignored.
REQ-012 The block SHALL provide Stall_F  input  1  downstream IR register not accepting.
REQ-013 The block SHALL provide Instr_F, PC_F, PCp4_F  output  `WORD_SIZE/`XLEN/`XLEN  head instruction, its PC, PC+4.
REQ-014 The block SHALL provide ValidInstruction_F  output  1  head outputs valid.

Function
REQ-015 Fetch PC register SHALL issue ImemReqValid_F when not redirecting and outstanding+occupancy < BUF_DEPTH; a request is accepted when ImemReqValid_F && ImemReqReady_F.
REQ-016 On acceptance fetch PC SHALL advance by 4 (modulo 2^XLEN, wraps silently); while ready is low ImemReqAdr_F SHALL hold stable.
REQ-017 Outstanding counter SHALL increment on accept, decrement on response, both same cycle = unchanged; never exceeds BUF_DEPTH.
REQ-018 Responses not being discarded SHALL enqueue {instr, PC} into a BUF_DEPTH-entry circular FIFO; PC tagging uses an in-order address queue or equivalent.
REQ-019 Outputs SHALL present the FIFO head; ValidInstruction_F = FIFO non-empty; PCp4_F = PC_F+4.
REQ-020 Head SHALL dequeue when ValidInstruction_F && !Stall_F; simultaneous enqueue and dequeue on a full FIFO SHALL be legal, occupancy unchanged.
REQ-021 Stall_F high SHALL hold all head outputs stable; Instr_F/PC_F are don't-care when ValidInstruction_F=0.
REQ-022 On Redirect_F: fetch PC <= {RedirectPC_F[XLEN-1:2],2'b00}; FIFO cleared; ImemReqValid_F=0 that cycle; discard counter <= outstanding minus any response arriving that cycle.
REQ-023 While discard counter > 0, each response SHALL be dropped and decrement it; first request after redirect issues the following cycle.
REQ-024 Redirect_F SHALL take priority over Stall_F, enqueue and dequeue in the same cycle.
REQ-025 Minimum latency, accept to ValidInstruction_F, SHALL be memory latency + 1 cycle (registered FIFO).

Reset
REQ-026 On reset: fetch PC=RESET_PC, FIFO empty, outstanding=0, discard=0, ImemReqValid_F=0, ValidInstruction_F=0.
REQ-027 Reset mid-operation SHALL abandon all in-flight state; responses arriving after reset with outstanding=0 SHALL be ignored.
REQ-028 Reset SHALL take priority over Redirect_F.

Configuration
REQ-029 Macro FETCH_BYPASS_EN defined: when FIFO empty, discard=0 and ImemRespValid_F=1, response SHALL drive outputs combinationally same cycle (ValidInstruction_F=1), enqueued only if Stall_F=1; latency drops to memory latency.
REQ-030 Macro FETCH_BYPASS_EN undefined: all responses SHALL pass through the FIFO; outputs driven only from registered state.

Verification
REQ-031 Reset, RESET_PC=0x0, ready=1, latency 1, no stall -> ReqAdr 0x0,0x4,0x8 on consecutive cycles; first ValidInstruction_F with PC_F=0x0, PCp4_F=0x4 two cycles after first accept (no bypass).
REQ-032 Stall_F=1 for 6 cycles, BUF_DEPTH=2 -> ReqValid drops once outstanding+occupancy=2; Instr_F/PC_F unchanged all 6 cycles; no instruction lost on release.
REQ-033 ImemReqReady_F=0 for 3 cycles at PC 0x8 -> ReqAdr held at 0x8, next accepted address 0xC.
REQ-034 Redirect to 0x103 with 2 outstanding -> both stale responses dropped; next valid instruction has PC_F=0x100, then 0x104.
REQ-035 Redirect_F and Stall_F together with full FIFO -> ValidInstruction_F=0 next cycle, discard counter equals outstanding.
REQ-036 Reset asserted with 2 outstanding, late response next cycle -> ValidInstruction_F stays 0, first post-reset ReqAdr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: instruction fetch front end.
//
// Issues word-aligned fetch requests from a PC register, tags the in-order
// responses with their PCs, and buffers them in a small circular FIFO. The
// FIFO head feeds the downstream IR register. A redirect reloads the PC,
// flushes the FIFO and arms a discard counter that drops responses still in
// flight for the abandoned path.
//
// Optional feature (macro FETCH_BYPASS_EN): when the FIFO is empty and no
// discards are pending, a live response drives the head outputs in the same
// cycle. It is written into the FIFO only if the consumer is stalled.
// Without the macro, the head outputs come from registered state only.
//
// Parameters
//   RESET_PC   PC of the first fetch after reset
//   BUF_DEPTH  instruction buffer entries (power of two, 2..8)
//
// Ports
//   clk                 sole clock, rising edge
//   reset               synchronous, active-high reset
//   ImemReqValid_F      fetch request valid
//   ImemReqReady_F      memory accepts the request this cycle
//   ImemReqAdr_F        fetch address (word aligned)
//   ImemRespValid_F     response beat valid (in order, no backpressure)
//   ImemRespData_F      fetched instruction
//   Redirect_F          PC redirect from downstream
//   RedirectPC_F        redirect target, bits [1:0] ignored
//   Stall_F             downstream IR register not accepting
//   Instr_F             head instruction
//   PC_F / PCp4_F       head PC and head PC + 4
//   ValidInstruction_F  head outputs valid
// -----------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module fetch_stage #(
  parameter logic [`XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned      BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ImemReqValid_F,
  input  logic                  ImemReqReady_F,
  output logic [`XLEN-1:0]      ImemReqAdr_F,
  input  logic                  ImemRespValid_F,
  input  logic [`WORD_SIZE-1:0] ImemRespData_F,
  input  logic                  Redirect_F,
  input  logic [`XLEN-1:0]      RedirectPC_F,
  input  logic                  Stall_F,
  output logic [`WORD_SIZE-1:0] Instr_F,
  output logic [`XLEN-1:0]      PC_F,
  output logic [`XLEN-1:0]      PCp4_F,
  output logic                  ValidInstruction_F
);

  localparam int unsigned XLen  = `XLEN;
  localparam int unsigned WordW = `WORD_SIZE;
  localparam int unsigned PtrW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SumW  = CntW + 1;

  typedef logic [XLen-1:0]  addr_t;
  typedef logic [WordW-1:0] word_t;
  typedef logic [CntW-1:0]  cnt_t;
  typedef logic [PtrW-1:0]  ptr_t;
  typedef logic [SumW-1:0]  sum_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  addr_t pc_q, pc_d;                     // next address to request
  addr_t resp_pc_q, resp_pc_d;           // PC of the next response to keep
  cnt_t  outstanding_q, outstanding_d;   // accepted, response not yet seen
  cnt_t  discard_q, discard_d;           // responses still to drop
  cnt_t  count_q, count_d;               // FIFO occupancy
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;

  word_t instr_mem_q [BUF_DEPTH];
  addr_t pc_mem_q    [BUF_DEPTH];

  // ---------------------------------------------------------------------------
  // Response classification
  // ---------------------------------------------------------------------------
  logic  resp_live;
  logic  resp_drop;
  logic  resp_keep;
  logic  fifo_empty;
  logic  bypass;
  logic  deq;
  logic  enq;
  logic  accept;
  sum_t  occ_sum;
  addr_t redirect_pc;
  logic  unused_redirect_lsb;

  // A beat with nothing outstanding belongs to a request abandoned by reset.
  assign resp_live  = ImemRespValid_F && (outstanding_q != '0);
  assign resp_drop  = resp_live && (discard_q != '0);
  assign resp_keep  = resp_live && (discard_q == '0);
  assign fifo_empty = (count_q == '0);

  assign redirect_pc         = {RedirectPC_F[XLen-1:2], 2'b00};
  assign unused_redirect_lsb = ^RedirectPC_F[1:0];

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && fifo_empty && !Redirect_F && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign deq = !fifo_empty && !Stall_F;
  // A bypassed beat consumed this cycle never needs a FIFO slot.
  assign enq = resp_keep && !(bypass && !Stall_F);

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // Every accepted request must have a guaranteed FIFO slot for its response.
  // Counting this cycle's dequeue lets a free-running stream sustain one
  // request per cycle with the minimum buffer depth.
  assign occ_sum = sum_t'(outstanding_q) + sum_t'(count_q) - sum_t'(deq);

  assign ImemReqValid_F = !reset && !Redirect_F && (occ_sum < sum_t'(BUF_DEPTH));
  assign ImemReqAdr_F   = pc_q;
  assign accept         = ImemReqValid_F && ImemReqReady_F;

  // ---------------------------------------------------------------------------
  // Head outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    if (bypass) begin
      Instr_F = ImemRespData_F;
      PC_F    = resp_pc_q;
    end else begin
      Instr_F = instr_mem_q[rd_ptr_q];
      PC_F    = pc_mem_q[rd_ptr_q];
    end
  end

  assign PCp4_F             = PC_F + addr_t'(4);
  assign ValidInstruction_F = !reset && (!fifo_empty || bypass);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(resp_live);

    if (Redirect_F) begin
      // No request issues this cycle, so whatever remains outstanding after
      // this cycle's beat belongs to the old path.
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      discard_d = outstanding_q - cnt_t'(resp_live);
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (accept) begin
        pc_d = pc_q + addr_t'(4);
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + addr_t'(4);
      end
      discard_d = discard_q - cnt_t'(resp_drop);
      wr_ptr_d  = wr_ptr_q + ptr_t'(enq);
      rd_ptr_d  = rd_ptr_q + ptr_t'(deq);
      count_d   = count_q + cnt_t'(enq) - cnt_t'(deq);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Buffer storage needs no reset: occupancy alone qualifies the head.
  always_ff @(posedge clk) begin
    if (enq && !Redirect_F && !reset) begin
      instr_mem_q[wr_ptr_q] <= ImemRespData_F;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`ifndef XLEN
`define XLEN 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0;
  localparam int unsigned Depth   = 2;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_adr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        stall_in;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcp4;
  logic        vi;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (ResetPc),
    .BUF_DEPTH(Depth)
  ) dut (
    .clk               (clk),
    .reset             (rst_in),
    .ImemReqValid_F    (req_valid),
    .ImemReqReady_F    (req_ready),
    .ImemReqAdr_F      (req_adr),
    .ImemRespValid_F   (resp_valid),
    .ImemRespData_F    (resp_data),
    .Redirect_F        (redirect_in),
    .RedirectPC_F      (redirect_pc_in),
    .Stall_F           (stall_in),
    .Instr_F           (instr),
    .PC_F              (pc),
    .PCp4_F            (pcp4),
    .ValidInstruction_F(vi)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] adr;
  } pend_t;

  exp_t  sb[$];
  pend_t pend[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  logic        ctl_rst, ctl_stall, ctl_ready, ctl_redirect;
  logic [31:0] ctl_redirect_pc;

  logic        s_req_v, s_vi;
  logic [31:0] s_req_adr, s_instr, s_pc, s_pcp4;

  function automatic logic [31:0] idata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: memory model, drive, sample at the falling edge, score.
  task automatic cycle();
    logic        rv;
    logic [31:0] radr;
    exp_t        e;
    rv   = 1'b0;
    radr = '0;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        rv   = 1'b1;
        radr = pend[0].adr;
        pend.delete(0);
      end
    end
    rst_in         = ctl_rst;
    resp_valid     = rv;
    resp_data      = rv ? idata(radr) : 32'h0;
    stall_in       = ctl_stall;
    req_ready      = ctl_ready;
    redirect_in    = ctl_redirect;
    redirect_pc_in = ctl_redirect_pc;
    #4;
    s_req_v   = req_valid;
    s_req_adr = req_adr;
    s_vi      = vi;
    s_instr   = instr;
    s_pc      = pc;
    s_pcp4    = pcp4;
    if (ctl_rst || ctl_redirect) begin
      sb.delete();
    end else if (s_vi && !ctl_stall) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got instr %h pc %h want no valid instruction", s_instr, s_pc);
      end else begin
        e = sb.pop_front();
        if (s_instr !== e.instr || s_pc !== e.pc || s_pcp4 !== e.pc + 32'd4) begin
          errors++;
          $display("FAIL sb_head: got instr %h pc %h pcp4 %h want instr %h pc %h pcp4 %h",
                   s_instr, s_pc, s_pcp4, e.instr, e.pc, e.pc + 32'd4);
        end
      end
    end
    if (s_req_v && ctl_ready) begin
      pend.push_back('{due: cyc + lat, adr: s_req_adr});
      if (!ctl_rst && !ctl_redirect) sb.push_back('{pc: s_req_adr, instr: idata(s_req_adr)});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_ctl();
    ctl_rst         = 1'b0;
    ctl_stall       = 1'b0;
    ctl_ready       = 1'b0;
    ctl_redirect    = 1'b0;
    ctl_redirect_pc = 32'h0;
  endtask

  task automatic drain();
    idle_ctl();
    for (int i = 0; i < 40; i++) begin
      if (pend.size() == 0 && sb.size() == 0) break;
      cycle();
    end
    checks++;
    if (pend.size() != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending %0d expected left want 0 0", pend.size(), sb.size());
    end
  endtask

  task automatic do_reset();
    idle_ctl();
    ctl_rst = 1'b1;
    cycle();
    cycle();
    ctl_rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_ctl();
    ctl_rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (s_req_v !== 1'b0 || s_vi !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req_v %b vi %b want 0 0", s_req_v, s_vi);
    end
    ctl_rst = 1'b0;
    cycle();
    checks++;
    if (s_req_v !== 1'b1 || s_req_adr !== ResetPc || s_vi !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_req: got req_v %b adr %h vi %b want 1 %h 0",
               s_req_v, s_req_adr, s_vi, ResetPc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want_adr;
    lat = 1;
    do_reset();
    ctl_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      want_adr = 32'(i * 4);
      checks++;
      if (s_req_v !== 1'b1 || s_req_adr !== want_adr) begin
        errors++;
        $display("FAIL stream_adr%0d: got req_v %b adr %h want 1 %h", i, s_req_v, s_req_adr,
                 want_adr);
      end
      checks++;
      if (s_vi !== (i == 2)) begin
        errors++;
        $display("FAIL stream_vi%0d: got %b want %b", i, s_vi, i == 2);
      end
    end
    checks++;
    if (s_pc !== 32'h0 || s_pcp4 !== 32'h4) begin
      errors++;
      $display("FAIL stream_first_pc: got pc %h pcp4 %h want 0 4", s_pc, s_pcp4);
    end
    for (int i = 0; i < 8; i++) cycle();
    drain();
  endtask

  task automatic test_stall();
    lat = 1;
    do_reset();
    ctl_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    ctl_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (s_req_v !== 1'b0) begin
        errors++;
        $display("FAIL stall_req_v%0d: got %b want 0", i, s_req_v);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stall_head%0d: got empty scoreboard want a held head", i);
      end else if (s_vi !== 1'b1 || s_instr !== sb[0].instr || s_pc !== sb[0].pc) begin
        errors++;
        $display("FAIL stall_head%0d: got vi %b instr %h pc %h want 1 %h %h",
                 i, s_vi, s_instr, s_pc, sb[0].instr, sb[0].pc);
      end
    end
    ctl_stall = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    drain();
  endtask

  task automatic test_ready_hold();
    lat = 1;
    do_reset();
    ctl_ready = 1'b1;
    cycle();
    cycle();
    ctl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_req_v !== 1'b1 || s_req_adr !== 32'h8) begin
        errors++;
        $display("FAIL ready_hold%0d: got req_v %b adr %h want 1 00000008", i, s_req_v, s_req_adr);
      end
    end
    ctl_ready = 1'b1;
    cycle();
    checks++;
    if (s_req_v !== 1'b1 || s_req_adr !== 32'h8) begin
      errors++;
      $display("FAIL ready_accept: got req_v %b adr %h want 1 00000008", s_req_v, s_req_adr);
    end
    cycle();
    checks++;
    if (s_req_v !== 1'b1 || s_req_adr !== 32'hC) begin
      errors++;
      $display("FAIL ready_next: got req_v %b adr %h want 1 0000000c", s_req_v, s_req_adr);
    end
    drain();
  endtask

  task automatic test_redirect();
    logic [31:0] pcs [2];
    int          got;
    lat = 2;
    do_reset();
    ctl_ready = 1'b1;
    cycle();
    cycle();
    ctl_redirect    = 1'b1;
    ctl_redirect_pc = 32'h103;
    cycle();
    checks++;
    if (s_req_v !== 1'b0) begin
      errors++;
      $display("FAIL redirect_req_v: got %b want 0", s_req_v);
    end
    ctl_redirect = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      cycle();
      if (s_vi) begin
        pcs[got] = s_pc;
        got++;
      end
    end
    checks++;
    if (got < 2) begin
      errors++;
      $display("FAIL redirect_timeout: got %0d instructions want 2", got);
    end else if (pcs[0] !== 32'h100 || pcs[1] !== 32'h104) begin
      errors++;
      $display("FAIL redirect_pcs: got %h %h want 00000100 00000104", pcs[0], pcs[1]);
    end
    drain();
  endtask

  task automatic test_redirect_stall();
    lat = 1;
    do_reset();
    ctl_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    ctl_stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    ctl_redirect    = 1'b1;
    ctl_redirect_pc = 32'h200;
    cycle();
    checks++;
    if (s_req_v !== 1'b0) begin
      errors++;
      $display("FAIL redir_stall_req_v: got %b want 0", s_req_v);
    end
    ctl_redirect = 1'b0;
    ctl_stall    = 1'b0;
    cycle();
    checks++;
    if (s_vi !== 1'b0 || s_req_v !== 1'b1 || s_req_adr !== 32'h200) begin
      errors++;
      $display("FAIL redir_stall_next: got vi %b req_v %b adr %h want 0 1 00000200",
               s_vi, s_req_v, s_req_adr);
    end
    for (int i = 0; i < 5; i++) cycle();
    drain();
  endtask

  task automatic test_reset_midflight();
    lat = 2;
    do_reset();
    ctl_ready = 1'b1;
    cycle();
    cycle();
    ctl_rst = 1'b1;
    cycle();
    checks++;
    if (s_req_v !== 1'b0) begin
      errors++;
      $display("FAIL midreset_req_v: got %b want 0", s_req_v);
    end
    ctl_rst = 1'b0;
    cycle();
    checks++;
    if (s_vi !== 1'b0 || s_req_v !== 1'b1 || s_req_adr !== ResetPc) begin
      errors++;
      $display("FAIL midreset_first: got vi %b req_v %b adr %h want 0 1 %h",
               s_vi, s_req_v, s_req_adr, ResetPc);
    end
    ctl_ready = 1'b0;
    cycle();
    checks++;
    if (s_vi !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stray: got vi %b instr %h want 0", s_vi, s_instr);
    end
    for (int i = 0; i < 4; i++) cycle();
    drain();
  endtask

  task automatic test_back_to_back();
    for (int seg = 1; seg <= 2; seg++) begin
      lat = seg;
      do_reset();
      for (int i = 0; i < 150; i++) begin
        ctl_stall       = ($urandom_range(0, 3) == 0);
        ctl_ready       = ($urandom_range(0, 3) != 0);
        ctl_redirect    = ($urandom_range(0, 19) == 0);
        ctl_redirect_pc = $urandom;
        cycle();
      end
      drain();
    end
  endtask

  initial begin
    idle_ctl();
    rst_in         = 1'b1;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = 32'h0;
    redirect_in    = 1'b0;
    redirect_pc_in = 32'h0;
    stall_in       = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_ready_hold();
    test_redirect();
    test_redirect_stall();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
